// File: rtl/obi_stream_reader.sv
// OBI read initiator: fetches a strided run of words and streams them out.
// obi_req_o = {req, addr[31:0], we, be[3:0], wdata[31:0]}; obi_resp_i = {gnt, rvalid, rdata[31:0]}.
module obi_stream_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      base_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [31:0]      stride_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [69:0]      obi_req_o,
   input  logic [33:0]      obi_resp_i,
   output logic [31:0]      data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      stride_q, stride_d;
   logic [LEN_W-1:0] issue_q, issue_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             done_q, done_d;
   logic [31:0]      mem_q [FIFO_DEPTH];

   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        req;
   logic        credit_ok;
   logic        issue;
   logic        push;
   logic        pop;

   assign gnt    = obi_resp_i[33];
   assign rvalid = obi_resp_i[32];
   assign rdata  = obi_resp_i[31:0];

   // outstanding + buffered never exceeds depth, so every response has a slot
   assign credit_ok = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C;
   assign req   = (state_q == S_RUN) && (issue_q != '0) && credit_ok;
   assign issue = req & gnt;
   assign push  = rvalid & (outst_q != '0);
   assign pop   = valid_o & ready_i;

   assign obi_req_o = {req, addr_q, 1'b0, 4'hF, 32'h0};
   assign valid_o   = cnt_q != '0;
   assign data_o    = mem_q[rptr_q];
   assign busy_o    = state_q != S_IDLE;
   assign done_o    = done_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      issue_d  = issue_q;
      left_d   = left_q;
      done_d   = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d  = S_RUN;
                  addr_d   = base_i & 32'hFFFF_FFFC;
                  stride_d = stride_i & 32'hFFFF_FFFC;
                  issue_d  = len_i;
                  left_d   = len_i;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         (state_q == S_RUN): begin
            if (issue) begin
               addr_d  = addr_q + stride_q;
               issue_d = issue_q - LEN_W'(1);
               if (issue_q == LEN_W'(1)) state_d = S_DRAIN;
            end
         end
         (state_q == S_DRAIN): ;
         default: state_d = S_IDLE;
      endcase
      if (pop && state_q != S_IDLE) begin
         left_d = left_q - LEN_W'(1);
         if (left_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      outst_d = outst_q;
      if (issue && !push) outst_d = outst_q + CNT_W'(1);
      else if (!issue && push) outst_d = outst_q - CNT_W'(1);
      cnt_d = cnt_q;
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
      wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         issue_q  <= '0;
         left_q   <= '0;
         outst_q  <= '0;
         cnt_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         issue_q  <= issue_d;
         left_q   <= left_d;
         outst_q  <= outst_d;
         cnt_q    <= cnt_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         done_q   <= done_d;
         if (push) mem_q[wptr_q] <= rdata;
      end
   end

   // a response with nothing outstanding means the slave was not reset with us
   a_no_stray_rvalid: assert property (
      @(posedge clk_i) disable iff (rst_i) rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_obi_stream_reader.sv
// Directed bench for obi_stream_reader with an in-order OBI slave model.
module tb_obi_stream_reader;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [31:0] base;
   logic [15:0] len;
   logic [31:0] stride;
   logic        busy;
   logic        done;
   logic [69:0] obi_req;
   logic [33:0] obi_resp;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] addr;

   assign obi_resp = {gnt, rvalid, rdata};
   assign req      = obi_req[69];
   assign addr     = obi_req[68:37];

   obi_stream_reader #(.FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .base_i     (base),
      .len_i      (len),
      .stride_i   (stride),
      .busy_o     (busy),
      .done_o     (done),
      .obi_req_o  (obi_req),
      .obi_resp_i (obi_resp),
      .data_o     (data),
      .valid_o    (valid),
      .ready_i    (ready)
   );

   typedef struct {
      logic [31:0] base;
      logic [15:0] len;
      logic [31:0] stride;
      int          gdly;
      int          lat;
      int          rmode;
      logic [31:0] exp_last;
   } vec_t;

   int          n_cmp;
   int          n_err;
   int          gnt_dly;
   bit          gnt_rnd;
   int          rv_lat;
   bit          rv_rnd;
   int          cyc;
   int          wait_cnt;
   logic [31:0] q_data[$];
   int          q_due[$];
   int          gcnt;
   int          rcnt;
   int          pcnt;
   int          dcnt;
   int          first_gcyc;
   int          last_gcyc;
   logic [31:0] last_gaddr;
   logic [31:0] mbase;
   logic [31:0] mstride;
   bit          prev_stall;
   logic [31:0] prev_addr;
   bit          prev_hold;
   logic [31:0] prev_data;
   vec_t        vt[5];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Slave and scoreboard, evaluated once per cycle on the falling edge
   task automatic slave_step();
      if (rst) begin
         gnt = 1'b0;
         rvalid = 1'b0;
         rdata = '0;
         q_data.delete();
         q_due.delete();
         gcnt = 0;
         rcnt = 0;
         pcnt = 0;
         dcnt = 0;
         wait_cnt = 0;
         prev_stall = 1'b0;
         prev_hold = 1'b0;
         return;
      end
      cyc++;
      if (prev_hold) begin
         chk("hold_valid", 32'(valid), 32'd1);
         chk("hold_data", data, prev_data);
      end
      if (prev_stall) begin
         chk("req_hold", 32'(req), 32'd1);
         chk("addr_hold", addr, prev_addr);
      end
      if (done) begin
         dcnt++;
         chk("done_busy", 32'(busy), 32'd0);
      end
      if (valid && ready) begin
         chk("data", data, mem_word(mbase + 32'(pcnt) * mstride));
         pcnt++;
      end
      prev_hold = valid && !ready;
      prev_data = data;
      rvalid = (q_due.size() > 0) && (q_due[0] <= cyc);
      rdata = rvalid ? q_data[0] : 32'h0;
      if (rvalid) begin
         void'(q_data.pop_front());
         void'(q_due.pop_front());
         rcnt++;
      end
      if (gnt_rnd) gnt = req && ($urandom_range(0, 2) != 0);
      else gnt = req && (wait_cnt >= gnt_dly);
      prev_stall = req && !gnt;
      prev_addr = addr;
      if (req && gnt) begin
         chk("addr", addr, mbase + 32'(gcnt) * mstride);
         q_data.push_back(mem_word(addr));
         q_due.push_back(cyc + (rv_rnd ? int'($urandom_range(1, 4)) : rv_lat));
         if (gcnt == 0) first_gcyc = cyc;
         last_gcyc = cyc;
         last_gaddr = addr;
         gcnt++;
         wait_cnt = 0;
      end else if (req) begin
         wait_cnt++;
      end
      chk("credit", 32'((gcnt - pcnt) <= DEPTH), 32'd1);
   endtask

   task automatic cycle();
      @(negedge clk);
      slave_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [15:0] l,
                           input logic [31:0] s);
      mbase = b & 32'hFFFF_FFFC;
      mstride = s;
      base = b;
      len = l;
      stride = s;
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input int rmode);
      int c;
      c = 0;
      while (dcnt == 0 && c < bound) begin
         if (rmode == 0) ready = 1'b1;
         else if (rmode == 1) ready = (c % 2) == 0;
         else ready = 1'($urandom_range(0, 1));
         cycle();
         c++;
      end
      chk("done_seen", 32'(dcnt != 0), 32'd1);
      ready = 1'b1;
      repeat (3) cycle();
      chk("done_once", 32'(dcnt), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      rst = 1'b1;
      start = 1'b0;
      base = '0;
      len = '0;
      stride = '0;
      ready = 1'b0;
      gnt = 1'b0;
      rvalid = 1'b0;
      rdata = '0;
      gnt_dly = 0;
      gnt_rnd = 1'b0;
      rv_lat = 1;
      rv_rnd = 1'b0;
      mbase = '0;
      mstride = '0;
      vt[0] = '{32'h0000_0100, 16'd4, 32'h4,         0, 1, 0, 32'h0000_010C};
      vt[1] = '{32'h0000_0010, 16'd4, 32'hFFFF_FFF8, 3, 1, 0, 32'hFFFF_FFF8};
      vt[2] = '{32'h0000_0203, 16'd3, 32'h10,        1, 2, 1, 32'h0000_0220};
      vt[3] = '{32'hFFFF_FFFC, 16'd2, 32'h4,         0, 3, 1, 32'h0000_0000};
      vt[4] = '{32'h0000_1000, 16'd6, 32'h100,       2, 2, 2, 32'h0000_1500};
      do_reset();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", data, 32'd0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         gnt_dly = vt[i].gdly;
         rv_lat = vt[i].lat;
         do_start(vt[i].base, vt[i].len, vt[i].stride);
         wait_done(400, vt[i].rmode);
         chk("vec_grants", 32'(gcnt), 32'(vt[i].len));
         chk("vec_pops", 32'(pcnt), 32'(vt[i].len));
         chk("vec_last_addr", last_gaddr, vt[i].exp_last);
         chk("vec_idle", 32'(busy), 32'd0);
      end

      // first request one cycle after start, then one grant per cycle
      do_reset();
      gnt_dly = 0;
      rv_lat = 1;
      ready = 1'b1;
      do_start(32'h100, 16'd4, 32'd4);
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_req", 32'(req), 32'd1);
      chk("lat_addr", addr, 32'h100);
      wait_done(100, 0);
      chk("b2b_span", 32'(last_gcyc - first_gcyc), 32'd3);

      // credit stall with the stream blocked
      do_reset();
      ready = 1'b0;
      do_start(32'h400, 16'd8, 32'd4);
      repeat (20) cycle();
      chk("stall_grants", 32'(gcnt), 32'd4);
      chk("stall_req", 32'(req), 32'd0);
      chk("stall_valid", 32'(valid), 32'd1);
      wait_done(200, 0);
      chk("stall_grants_all", 32'(gcnt), 32'd8);
      chk("stall_pops", 32'(pcnt), 32'd8);

      // zero-length transfer
      do_reset();
      do_start(32'h500, 16'd0, 32'd4);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_req", 32'(req), 32'd0);
      cycle();
      chk("zero_done_pulse", 32'(done), 32'd0);
      chk("zero_grants", 32'(gcnt), 32'd0);

      // start while busy is ignored
      do_reset();
      gnt_dly = 3;
      ready = 1'b1;
      do_start(32'h100, 16'd4, 32'd4);
      cycle();
      cycle();
      base = 32'h900;
      len = 16'd2;
      stride = 32'h40;
      start = 1'b1;
      cycle();
      start = 1'b0;
      wait_done(200, 0);
      chk("ign_grants", 32'(gcnt), 32'd4);
      chk("ign_last", last_gaddr, 32'h10C);
      chk("ign_pops", 32'(pcnt), 32'd4);

      // reset with two outstanding and two buffered
      do_reset();
      gnt_dly = 0;
      rv_lat = 2;
      ready = 1'b0;
      do_start(32'h600, 16'd8, 32'd4);
      repeat (4) cycle();
      chk("pre_outst", 32'(gcnt - rcnt), 32'd2);
      chk("pre_count", 32'(rcnt - pcnt), 32'd2);
      chk("pre_valid", 32'(valid), 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_req", 32'(req), 32'd0);
      chk("mid_addr", addr, 32'd0);
      chk("mid_valid", 32'(valid), 32'd0);
      chk("mid_data", data, 32'd0);
      gnt_dly = 1;
      rv_lat = 1;
      do_start(32'h700, 16'd5, 32'd8);
      wait_done(200, 0);
      chk("post_grants", 32'(gcnt), 32'd5);
      chk("post_pops", 32'(pcnt), 32'd5);
      chk("post_last", last_gaddr, 32'h720);

      // long random run
      do_reset();
      gnt_rnd = 1'b1;
      rv_rnd = 1'b1;
      do_start(32'h8000_0000, 16'd1000, 32'd4);
      wait_done(20000, 2);
      chk("rnd_grants", 32'(gcnt), 32'd1000);
      chk("rnd_pops", 32'(pcnt), 32'd1000);
      gnt_rnd = 1'b0;
      rv_rnd = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
